collision_edge_detector: RTL and testbench
==========================================

# collision_edge_detector

Frame-based collision reader for the bitmap drawers. Samples the player bitmap's registered `drawingRequest`/`HitEdgeCode` together with the drawing requests of up to `NUM_TARGETS` target objects (bricks, borders) on every pixel clock. Accumulates overlaps across one VGA frame and, at the next start of frame, emits a single one-cycle collision report. Sits between the drawer outputs and the game-control / player-movement logic.

## Interface
- `NUM_TARGETS`, 4: number of target drawing-request inputs (1..16).
- `COUNT_W`, 8: width of the saturating overlap-pixel counter.

- `clk`  in  1  pixel clock.
- `resetN`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `startOfFrame`  in  1  one-cycle pulse at frame start.
- `enable`  in  1  accumulation enable; low ignores overlaps.
- `playerDrawingRequest`  in  1  player bitmap pixel opaque, registered by the drawer.
- `playerHitEdgeCode`  in  4  {Left, Top, Right, Bottom}, aligned with `playerDrawingRequest`.
- `targetDrawingRequest`  in  NUM_TARGETS  per-target opaque pixel, same alignment.
- `collision`  out  1  one-cycle report pulse.
- `collisionEdgeCode`  out  4  OR of player edge codes over all overlap pixels of the reported frame.
- `collisionTargetMask`  out  NUM_TARGETS  targets that overlapped during the reported frame.
- `firstTarget`  out  $clog2(NUM_TARGETS)  lowest index among targets overlapping on the first overlap cycle of the frame.
- `overlapCount`  out  COUNT_W  number of overlap cycles in the reported frame, saturating.

## Operation
- Overlap cycle: `enable & playerDrawingRequest & |targetDrawingRequest`.
- FSM states: `IDLE`, `SCAN`, `REPORT`.
  - `IDLE`: after reset. Ignores overlaps. Goes to `SCAN` on `startOfFrame`.
  - `SCAN`: on each overlap cycle:
    - edge accumulator |= `playerHitEdgeCode`;
    - mask accumulator |= `targetDrawingRequest`;
    - counter += 1, saturating at 2^COUNT_W−1.
    - On the frame's first overlap, latch the lowest set index of `targetDrawingRequest` as the first target; later overlaps never change it.
  - On `startOfFrame` in `SCAN`:
    - if counter > 0, copy the accumulators to the output registers and go to `REPORT`; otherwise stay in `SCAN`.
    - Either way, clear the accumulators in the same edge.
  - `REPORT`: lasts exactly one cycle. `collision`=1. Accumulates the current cycle as a new-frame overlap. Returns to `SCAN`.
- Report outputs other than `collision` hold their values until the next report.
- `enable` low: overlaps are not counted. FSM and frame boundaries still advance.

## Timing
- Reset values: `collision`=0, `collisionEdgeCode`=0, `collisionTargetMask`=0, `firstTarget`=0, `overlapCount`=0, state `IDLE`, all accumulators 0.
- Inputs are sampled directly. The drawer already registers its outputs, so no extra alignment stage is needed.
- Latency: `startOfFrame` sampled at edge N → `collision` high from edge N to edge N+1 only.
- Simultaneous overlap and `startOfFrame`:
  - the overlap belongs to the new frame;
  - it is loaded into the cleared accumulators (counter=1, first target latched);
  - it is not part of the report.
- `startOfFrame` while in `REPORT`: treated like the `SCAN` case, so back-to-back reports are allowed.
- `startOfFrame` in `IDLE` with a simultaneous overlap: the overlap is counted as the first frame's.
- Reset asserted mid-frame: everything returns to reset values immediately. Any pending report is discarded.

## Structure
- Shared package `collision_pkg`:
  - edge bit indices `EDGE_LEFT`=3, `EDGE_TOP`=2, `EDGE_RIGHT`=1, `EDGE_BOTTOM`=0;
  - FSM enum `coll_state_t`;
  - type `edge_code_t` (logic [3:0]).
- Sub-module `lowest_index_encoder`: parameterised combinational priority encoder producing the first-target index.
- Everything else lives in one `always_ff` plus next-state logic.

## Test plan
- Reset, then frame with no overlaps, then `startOfFrame` → `collision` stays 0; all outputs 0.
- 3 overlap cycles with target mask 4'b0100 and player edges 4'h8, 4'hC, 4'h8, then `startOfFrame` → one-cycle `collision` with edge 4'hC, mask 4'b0100, first target 2, count 3.
- First overlap mask 4'b1010, later 4'b0001 → first target 1, mask 4'b1011.
- 300 overlap cycles with `COUNT_W`=8 → count 255.
- Overlap coincident with `startOfFrame` → excluded from this report; appears in the next report with count 1.
- `resetN` pulsed low mid-frame after 5 overlaps, then a clean frame → no report for the interrupted frame; state returns to `IDLE`.

Source files
------------

// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types and constants for the collision reader
package collision_pkg;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef logic [3:0] edge_code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } coll_state_t;

endpackage

// File: rtl/lowest_index_encoder.sv
// rtl/lowest_index_encoder.sv - combinational priority encoder, lowest set bit wins
module lowest_index_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/collision_edge_detector.sv
// rtl/collision_edge_detector.sv - per-frame player/target overlap accumulator and reporter
module collision_edge_detector
  import collision_pkg::*;
#(
  parameter  int NUM_TARGETS = 4,
  parameter  int COUNT_W     = 8,
  localparam int IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   enable,
  input  logic                   playerDrawingRequest,
  input  logic [3:0]             playerHitEdgeCode,
  input  logic [NUM_TARGETS-1:0] targetDrawingRequest,
  output logic                   collision,
  output logic [3:0]             collisionEdgeCode,
  output logic [NUM_TARGETS-1:0] collisionTargetMask,
  output logic [IDX_W-1:0]       firstTarget,
  output logic [COUNT_W-1:0]     overlapCount
);

  coll_state_t            state_q, state_d;
  edge_code_t             edge_acc_q, edge_acc_d;
  logic [NUM_TARGETS-1:0] mask_acc_q, mask_acc_d;
  logic [IDX_W-1:0]       first_acc_q, first_acc_d;
  logic [COUNT_W-1:0]     cnt_acc_q, cnt_acc_d;

  logic                   collision_q, collision_d;
  edge_code_t             edge_out_q, edge_out_d;
  logic [NUM_TARGETS-1:0] mask_out_q, mask_out_d;
  logic [IDX_W-1:0]       first_out_q, first_out_d;
  logic [COUNT_W-1:0]     count_out_q, count_out_d;

  logic                   overlap;
  logic                   accumulate;
  logic [IDX_W-1:0]       lowest_idx;

  lowest_index_encoder #(
    .WIDTH (NUM_TARGETS),
    .IDX_W (IDX_W)
  ) u_lowest_index_encoder (
    .req_i (targetDrawingRequest),
    .idx_o (lowest_idx)
  );

  assign overlap = enable & playerDrawingRequest & (|targetDrawingRequest);

  // IDLE only listens once the first frame boundary arrives.
  assign accumulate = overlap & ((state_q != IDLE) | startOfFrame);

  always_comb begin
    state_d     = state_q;
    edge_acc_d  = edge_acc_q;
    mask_acc_d  = mask_acc_q;
    first_acc_d = first_acc_q;
    cnt_acc_d   = cnt_acc_q;
    collision_d = 1'b0;
    edge_out_d  = edge_out_q;
    mask_out_d  = mask_out_q;
    first_out_d = first_out_q;
    count_out_d = count_out_q;

    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d = SCAN;
        end
      end
      SCAN, REPORT: begin
        state_d = SCAN;
        if (startOfFrame && (cnt_acc_q != '0)) begin
          state_d     = REPORT;
          collision_d = 1'b1;
          edge_out_d  = edge_acc_q;
          mask_out_d  = mask_acc_q;
          first_out_d = first_acc_q;
          count_out_d = cnt_acc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame boundary clears first, so a coincident overlap opens the new frame.
    if (startOfFrame) begin
      edge_acc_d  = '0;
      mask_acc_d  = '0;
      first_acc_d = '0;
      cnt_acc_d   = '0;
    end

    if (accumulate) begin
      edge_acc_d = edge_acc_d | playerHitEdgeCode;
      mask_acc_d = mask_acc_d | targetDrawingRequest;
      if (cnt_acc_d == '0) begin
        first_acc_d = lowest_idx;
      end
      if (cnt_acc_d != '1) begin
        cnt_acc_d = cnt_acc_d + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      edge_acc_q  <= '0;
      mask_acc_q  <= '0;
      first_acc_q <= '0;
      cnt_acc_q   <= '0;
      collision_q <= 1'b0;
      edge_out_q  <= '0;
      mask_out_q  <= '0;
      first_out_q <= '0;
      count_out_q <= '0;
    end else begin
      state_q     <= state_d;
      edge_acc_q  <= edge_acc_d;
      mask_acc_q  <= mask_acc_d;
      first_acc_q <= first_acc_d;
      cnt_acc_q   <= cnt_acc_d;
      collision_q <= collision_d;
      edge_out_q  <= edge_out_d;
      mask_out_q  <= mask_out_d;
      first_out_q <= first_out_d;
      count_out_q <= count_out_d;
    end
  end

  assign collision           = collision_q;
  assign collisionEdgeCode   = edge_out_q;
  assign collisionTargetMask = mask_out_q;
  assign firstTarget         = first_out_q;
  assign overlapCount        = count_out_q;

endmodule

// File: tb/tb_collision_edge_detector.sv
// tb/tb_collision_edge_detector.sv - directed self-checking bench for collision_edge_detector
module tb_collision_edge_detector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       enable;
  logic       playerDrawingRequest;
  logic [3:0] playerHitEdgeCode;
  logic [3:0] targetDrawingRequest;
  logic       collision;
  logic [3:0] collisionEdgeCode;
  logic [3:0] collisionTargetMask;
  logic [1:0] firstTarget;
  logic [7:0] overlapCount;

  logic [18:0] obs;
  int tests = 0;
  int failed = 0;

  collision_edge_detector #(
    .NUM_TARGETS (4),
    .COUNT_W     (8)
  ) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .enable               (enable),
    .playerDrawingRequest (playerDrawingRequest),
    .playerHitEdgeCode    (playerHitEdgeCode),
    .targetDrawingRequest (targetDrawingRequest),
    .collision            (collision),
    .collisionEdgeCode    (collisionEdgeCode),
    .collisionTargetMask  (collisionTargetMask),
    .firstTarget          (firstTarget),
    .overlapCount         (overlapCount)
  );

  always #5 clk = ~clk;

  // {collision, edge, mask, first, count}
  assign obs = {collision, collisionEdgeCode, collisionTargetMask, firstTarget, overlapCount};

  task automatic cyc(input logic sof, input logic en, input logic pdr,
                     input logic [3:0] ec, input logic [3:0] tdr);
    startOfFrame         = sof;
    enable               = en;
    playerDrawingRequest = pdr;
    playerHitEdgeCode    = ec;
    targetDrawingRequest = tdr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    startOfFrame = 1'b0; enable = 1'b0; playerDrawingRequest = 1'b0;
    playerHitEdgeCode = 4'h0; targetDrawingRequest = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    if (obs !== 19'h0) begin $display("FAIL reset_values got=%h exp=%h", obs, 19'h0); failed++; end
    tests++;
    resetN = 1'b1;
    cyc(0, 1, 0, 4'h0, 4'h0);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (collision !== 1'b0) begin $display("FAIL first_sof_no_report got=%b exp=0", collision); failed++; end
    tests++;
    cyc(0, 1, 1, 4'hF, 4'h0);
    cyc(0, 1, 0, 4'hF, 4'hF);
    cyc(0, 0, 0, 4'h0, 4'h0);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== 19'h0) begin $display("FAIL empty_frame got=%h exp=%h", obs, 19'h0); failed++; end
    tests++;
  endtask

  task automatic test_basic_report();
    cyc(0, 1, 1, 4'h8, 4'b0100);
    cyc(0, 1, 1, 4'hC, 4'b0100);
    cyc(0, 1, 1, 4'h8, 4'b0100);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b1, 4'hC, 4'b0100, 2'd2, 8'd3}) begin
      $display("FAIL basic_report got=%h exp=%h", obs, {1'b1, 4'hC, 4'b0100, 2'd2, 8'd3}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b0, 4'hC, 4'b0100, 2'd2, 8'd3}) begin
      $display("FAIL basic_hold got=%h exp=%h", obs, {1'b0, 4'hC, 4'b0100, 2'd2, 8'd3}); failed++;
    end
    tests++;
  endtask

  task automatic test_first_target();
    cyc(0, 0, 1, 4'hF, 4'b1111);
    cyc(0, 1, 1, 4'h1, 4'b1010);
    cyc(0, 1, 1, 4'h2, 4'b0001);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b1, 4'h3, 4'b1011, 2'd1, 8'd2}) begin
      $display("FAIL first_target got=%h exp=%h", obs, {1'b1, 4'h3, 4'b1011, 2'd1, 8'd2}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) cyc(0, 1, 1, 4'h0, 4'b0001);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b1, 4'h0, 4'b0001, 2'd0, 8'd255}) begin
      $display("FAIL saturate got=%h exp=%h", obs, {1'b1, 4'h0, 4'b0001, 2'd0, 8'd255}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
  endtask

  task automatic test_coincident();
    cyc(0, 1, 1, 4'h4, 4'b0010);
    cyc(0, 1, 1, 4'h4, 4'b0010);
    cyc(1, 1, 1, 4'h1, 4'b1000);
    if (obs !== {1'b1, 4'h4, 4'b0010, 2'd1, 8'd2}) begin
      $display("FAIL coincident_excluded got=%h exp=%h", obs, {1'b1, 4'h4, 4'b0010, 2'd1, 8'd2}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
    if (collision !== 1'b0) begin $display("FAIL report_one_cycle got=%b exp=0", collision); failed++; end
    tests++;
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b1, 4'h1, 4'b1000, 2'd3, 8'd1}) begin
      $display("FAIL coincident_next got=%h exp=%h", obs, {1'b1, 4'h1, 4'b1000, 2'd3, 8'd1}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    cyc(0, 1, 1, 4'h8, 4'b0100);
    cyc(1, 1, 1, 4'h2, 4'b0100);
    if (obs !== {1'b1, 4'h8, 4'b0100, 2'd2, 8'd1}) begin
      $display("FAIL b2b_first got=%h exp=%h", obs, {1'b1, 4'h8, 4'b0100, 2'd2, 8'd1}); failed++;
    end
    tests++;
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b1, 4'h2, 4'b0100, 2'd2, 8'd1}) begin
      $display("FAIL b2b_second got=%h exp=%h", obs, {1'b1, 4'h2, 4'b0100, 2'd2, 8'd1}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
    if (collision !== 1'b0) begin $display("FAIL b2b_end got=%b exp=0", collision); failed++; end
    tests++;
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 4'h1, 4'b0010);
    #2;
    resetN = 1'b0;
    #1;
    if (obs !== 19'h0) begin $display("FAIL async_reset got=%h exp=%h", obs, 19'h0); failed++; end
    tests++;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    cyc(0, 1, 1, 4'hF, 4'b1111);
    cyc(0, 1, 1, 4'hF, 4'b1111);
    cyc(1, 1, 1, 4'h8, 4'b0001);
    if (collision !== 1'b0) begin $display("FAIL reset_discard got=%b exp=0", collision); failed++; end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== {1'b1, 4'h8, 4'b0001, 2'd0, 8'd1}) begin
      $display("FAIL idle_first_frame got=%h exp=%h", obs, {1'b1, 4'h8, 4'b0001, 2'd0, 8'd1}); failed++;
    end
    tests++;
    cyc(0, 1, 0, 4'h0, 4'h0);
    if (collision !== 1'b0) begin $display("FAIL final_idle got=%b exp=0", collision); failed++; end
    tests++;
  endtask

  initial begin
    test_reset();
    test_basic_report();
    test_first_target();
    test_saturate();
    test_coincident();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
